// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared state encoding, vector table and truth-table model for the gate sweep.
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int NUM_VEC = 4;
  // Bit k holds the operand value for vector k: 00, 10, 01, 11 as (A,B).
  localparam logic [NUM_VEC-1:0] VEC_A = 4'b1010;
  localparam logic [NUM_VEC-1:0] VEC_B = 4'b1100;
  function automatic logic [2:0] expect_out(input logic [1:0] ab);
    return {ab[1] & ab[0], ab[1] | ab[0], ~ab[1]};
  endfunction
endpackage

// File: rtl/gate_sweep_ctrl_dwell_timer.sv
// dwell_timer: per-vector hold counter with terminal count at DWELL-1.
module dwell_timer #(
  parameter int CW    = 8,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_tc = r_cnt == CW'(DWELL - 1);
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives a gate unit through all four input vectors and checks its outputs.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iStart,
  input  logic       iAbort,
  output logic       oA,
  output logic       oB,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oBusy,
  output logic [1:0] oVecIdx,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oErrMap
);
  state_t r_state, w_next;
  logic r_launch, r_a, r_b, r_busy, r_done, r_pass;
  logic [1:0] r_idx;
  logic [3:0] r_err;
  logic w_tc, w_drive, w_accept, w_bad, w_clr;
  logic [1:0] w_nidx;
  logic [3:0] w_err;
  assign w_drive  = r_state == DRIVE;
  assign w_accept = r_state == IDLE && !r_launch && iStart;
  assign w_clr    = !w_drive || w_tc || iAbort;
  assign w_bad    = {iAnd, iOr, iNot} != expect_out({r_a, r_b});
  assign w_err    = r_err | (4'(w_bad) << r_idx);
  assign w_nidx   = r_idx + 2'd1;
  dwell_timer #(.CW(CW), .DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .i_en (w_drive),
    .o_tc (w_tc)
  );
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (r_launch ? DRIVE : IDLE) :
             (r_state == DRIVE) ? (iAbort ? IDLE : (w_tc && r_idx == 2'd3) ? DONE : DRIVE) :
                                  IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // A start is latched for one cycle so the first vector appears one edge after sampling.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_launch <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_idx    <= 2'd0;
      r_err    <= 4'd0;
    end else begin
      r_launch <= w_accept;
      r_done   <= 1'b0;
      if (w_accept) begin
        r_err  <= 4'd0;
        r_pass <= 1'b0;
      end
      if (r_state == IDLE && r_launch) begin
        r_busy <= 1'b1;
        r_idx  <= 2'd0;
        r_a    <= VEC_A[0];
        r_b    <= VEC_B[0];
      end
      if (w_drive && iAbort) begin
        r_busy <= 1'b0;
        r_idx  <= 2'd0;
        r_a    <= 1'b0;
        r_b    <= 1'b0;
        r_pass <= 1'b0;
      end else if (w_drive && w_tc) begin
        r_err <= w_err;
        if (r_idx == 2'd3) begin
          r_busy <= 1'b0;
          r_idx  <= 2'd0;
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          r_done <= 1'b1;
          r_pass <= w_err == 4'd0;
        end else begin
          r_idx <= w_nidx;
          r_a   <= VEC_A[w_nidx];
          r_b   <= VEC_B[w_nidx];
        end
      end
    end
  assign oA      = r_a;
  assign oB      = r_b;
  assign oBusy   = r_busy;
  assign oVecIdx = r_idx;
  assign oDone   = r_done;
  assign oPass   = r_pass;
  assign oErrMap = r_err;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: randomized sweeps on DWELL=4 and DWELL=2 instances against a cycle-level reference model.
module tb_gate_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic iStart = 1'b0;
  logic iAbort = 1'b0;
  int   sel = 4;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [2:0] cor [4];
  logic [1:0] tab [4];
  logic a4, b4, and4, or4, not4, busy4, done4, pass4;
  logic a2, b2, and2, or2, not2, busy2, done2, pass2;
  logic [1:0] idx4, idx2;
  logic [3:0] err4, err2;
  logic [10:0] obs4, obs2;
  always #5 clk = ~clk;
  // Gate unit models: true logic, optionally corrupted per input vector (index = A + 2B).
  assign {and4, or4, not4} = {a4 & b4, a4 | b4, ~a4} ^ cor[{b4, a4}];
  assign {and2, or2, not2} = {a2 & b2, a2 | b2, ~a2} ^ cor[{b2, a2}];
  assign obs4 = {busy4, idx4, a4, b4, done4, pass4, err4};
  assign obs2 = {busy2, idx2, a2, b2, done2, pass2, err2};
  gate_sweep_ctrl #(.DWELL(4), .CW(8)) dut4 (
    .clk(clk), .rst(rst), .iStart(iStart && sel == 4), .iAbort(iAbort && sel == 4),
    .oA(a4), .oB(b4), .iAnd(and4), .iOr(or4), .iNot(not4), .oBusy(busy4),
    .oVecIdx(idx4), .oDone(done4), .oPass(pass4), .oErrMap(err4)
  );
  gate_sweep_ctrl #(.DWELL(2), .CW(8)) dut2 (
    .clk(clk), .rst(rst), .iStart(iStart && sel == 2), .iAbort(iAbort && sel == 2),
    .oA(a2), .oB(b2), .iAnd(and2), .iOr(or2), .iNot(not2), .oBusy(busy2),
    .oVecIdx(idx2), .oDone(done2), .oPass(pass2), .oErrMap(err2)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [10:0] obs_sel();
    return (sel == 2) ? obs2 : obs4;
  endfunction
  function automatic logic [3:0] model_err();
    logic [3:0] e;
    for (int k = 0; k < 4; k++) e[k] = cor[k] != 3'b000;
    return e;
  endfunction
  // Expected {busy,idx,A,B,done,pass,errmap} in cycle n after the start-sampling edge.
  function automatic logic [10:0] exp_vec(input int d, input int n, input logic [3:0] e);
    int k;
    logic [3:0] m;
    logic [1:0] v;
    if (n <= 4 * d) begin
      k = (n - 1) / d;
      m = 4'((1 << k) - 1);
      v = tab[k];
      return {1'b1, 2'(k), v[1], v[0], 1'b0, 1'b0, e & m};
    end
    return {1'b0, 2'b00, 1'b0, 1'b0, n == 4 * d + 1, e == 4'd0, e};
  endfunction
  task automatic run_sweep(input string name, input int d, input bit noise, input bit with_abort);
    logic [3:0] e;
    logic [10:0] got, want;
    e = model_err();
    sel = d;
    iStart = 1'b1;
    iAbort = with_abort;
    step();
    iStart = 1'b0;
    iAbort = 1'b0;
    for (int n = 1; n <= 4 * d + 2; n++) begin
      step();
      got  = obs_sel();
      want = exp_vec(d, n, e);
      n_chk++;
      if (got !== want) $display("FAIL %s d=%0d cycle %0d: got %b want %b", name, d, n, got, want);
      else n_pass++;
      iStart = (noise && n <= 4 * d + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask
  task automatic set_cor(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] c3);
    cor[0] = c0;
    cor[1] = c1;
    cor[2] = c2;
    cor[3] = c3;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk += 2;
    if (obs4 !== 11'd0) $display("FAIL reset4: got %b want 0", obs4); else n_pass++;
    if (obs2 !== 11'd0) $display("FAIL reset2: got %b want 0", obs2); else n_pass++;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_clean();
    set_cor(3'b000, 3'b000, 3'b000, 3'b000);
    run_sweep("clean", 4, 1'b0, 1'b0);
  endtask
  task automatic test_faults();
    set_cor(3'b000, 3'b000, 3'b000, 3'b100);
    run_sweep("and_stuck0", 4, 1'b0, 1'b0);
    set_cor(3'b000, 3'b001, 3'b000, 3'b001);
    run_sweep("not_stuck1", 4, 1'b1, 1'b0);
  endtask
  task automatic test_abort();
    int d, ab_n;
    logic [10:0] got, want;
    d = 4;
    sel = d;
    ab_n = $urandom_range(2 * d + 1, 3 * d);
    set_cor(3'b000, 3'b010, 3'b000, 3'b000);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int n = 1; n <= ab_n; n++) begin
      step();
      got  = obs_sel();
      want = exp_vec(d, n, 4'b0010);
      n_chk++;
      if (got !== want) $display("FAIL abort_pre cycle %0d: got %b want %b", n, got, want);
      else n_pass++;
      iStart = (n < ab_n) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    for (int n = 0; n < 4 * d; n++) begin
      got = obs_sel();
      n_chk++;
      if (got !== 11'b000_0000_0010) $display("FAIL abort_idle +%0d: got %b want 00000000010", n, got);
      else n_pass++;
      step();
    end
  endtask
  task automatic test_reset_mid();
    sel = 4;
    set_cor(3'b000, 3'b000, 3'b000, 3'b000);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    repeat (6) step();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (obs4 !== 11'd0) $display("FAIL reset_mid: got %b want 0", obs4); else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if (obs4 !== 11'd0) $display("FAIL reset_mid_hold: got %b want 0", obs4); else n_pass++;
    run_sweep("after_reset", 4, 1'b0, 1'b1);
  endtask
  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      set_cor(3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}), 3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}),
              3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}), 3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}));
      run_sweep("dwell2_b2b", 2, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask
  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      set_cor(3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}), 3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}),
              3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}), 3'($urandom_range(0, 7) & {3{1'($urandom_range(0, 1))}}));
      run_sweep("random", ($urandom_range(0, 1) == 1) ? 4 : 2, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask
  initial begin
    tab[0] = 2'b00;
    tab[1] = 2'b10;
    tab[2] = 2'b01;
    tab[3] = 2'b11;
    set_cor(3'b000, 3'b000, 3'b000, 3'b000);
    test_reset();
    test_clean();
    test_faults();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
